// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// iteration counter width and FSM state encoding.
package div_pkg;

   localparam int unsigned DEF_DIVIDEND_W = 8;
   localparam int unsigned DEF_DIVISOR_W  = 4;
   localparam int unsigned DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : div_pkg

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done request and result bundle of the restoring divider.
//   master: drives start, dividend, divisor; observes busy, done and results
//   slave : the divider itself
interface seq_restoring_divider_if
   import div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
);

   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface : seq_restoring_divider_if

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   part_i   : current partial remainder (DIVISOR_W+1 bits)
//   bit_i    : next dividend bit shifted in
//   dvs_i    : divisor
//   part_o_c : next partial remainder
//   qbit_o_c : quotient bit produced by this step
module div_step #(
   parameter int unsigned DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   part_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] dvs_i,
   output logic [DIVISOR_W:0]   part_o_c,
   output logic                 qbit_o_c
);

   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W+1:0] diff;

   // The partial remainder MSB is always zero after a step, so the one extra
   // bit here only serves as the borrow-out of the trial subtraction.
   always_comb begin
      shifted  = {part_i, bit_i};
      diff     = shifted - {2'b00, dvs_i};
      qbit_o_c = ~diff[DIVISOR_W+1];
      part_o_c = (DIVISOR_W+1)'(qbit_o_c ? diff : shifted);
   end

endmodule : div_step

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seq_restoring_divider_if (start/operands in,
//                busy/done/quotient/remainder/div_by_zero out, all registered)
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
   input logic                     clk,
   input logic                     rst_n,
   seq_restoring_divider_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic [DIVISOR_W:0]    part_q, part_d;
   logic [DIVIDEND_W-1:0] quo_q, quo_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic                  dbz_q, dbz_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [DIVISOR_W:0]    step_part_c;
   logic                  step_qbit_c;
   logic [DIVIDEND_W-1:0] dvd_shift_c;

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .part_i   (part_q),
      .bit_i    (dvd_q[DIVIDEND_W-1]),
      .dvs_i    (dvs_q),
      .part_o_c (step_part_c),
      .qbit_o_c (step_qbit_c)
   );

   // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
   // the dividend register doubles as the working quotient.
   assign dvd_shift_c = {dvd_q[DIVIDEND_W-2:0], step_qbit_c};

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         part_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         part_q  <= part_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      part_d  = part_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               dvd_d  = bus.dividend;
               dvs_d  = bus.divisor;
               part_d = '0;
               cnt_d  = '0;
               quo_d  = '0;
               rem_d  = '0;
               dbz_d  = 1'b0;
               if (bus.divisor == '0) begin
                  // Division by zero skips the iterations entirely.
                  quo_d   = '1;
                  rem_d   = '1;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            part_d = step_part_c;
            dvd_d  = dvd_shift_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               quo_d   = dvd_shift_c;
               rem_d   = step_part_c[DIVISOR_W-1:0];
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the upcoming state.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: a cycle model decides when a
// start is accepted, pushes the expected result with its due cycle, and the
// per-cycle monitor pops and compares when done is due.
module tb_seq_restoring_divider;

   logic clk;
   logic rst_n;

   seq_restoring_divider_if dif ();

   seq_restoring_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   typedef struct {
      logic [7:0]  a;
      logic [3:0]  b;
      logic [7:0]  q;
      logic [3:0]  r;
      logic        dbz;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_cmp    = 0;
   int unsigned n_err    = 0;
   int unsigned cyc      = 0;
   int unsigned acc_cyc  = 0;
   int unsigned free_cyc = 0;
   int unsigned dbz_seen = 0;
   bit          chk_busy = 1'b1;
   bit          have_hold = 1'b0;
   logic [7:0]  hold_q;
   logic [3:0]  hold_r;
   logic        hold_dbz;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one clock: model acceptance before the edge, check after it.
   task automatic step();
      exp_t e;
      logic exp_done;
      if (dif.start && rst_n && cyc >= free_cyc) begin
         e.a = dif.dividend;
         e.b = dif.divisor;
         if (e.b == 4'd0) begin
            e.q      = 8'hFF;
            e.r      = 4'hF;
            e.dbz    = 1'b1;
            e.cyc    = cyc + 1;
            free_cyc = cyc + 2;
         end else begin
            e.q      = e.a / 8'(e.b);
            e.r      = 4'(e.a % 8'(e.b));
            e.dbz    = 1'b0;
            e.cyc    = cyc + 9;
            free_cyc = cyc + 10;
         end
         acc_cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (chk_busy)
         chk("busy", 32'(dif.busy), 32'(cyc > acc_cyc && cyc < free_cyc));
      if (dif.done || exp_done)
         chk("done", 32'(dif.done), 32'(exp_done));
      if (exp_done) begin
         e = sb.pop_front();
         chk("quotient", 32'(dif.quotient), 32'(e.q));
         chk("remainder", 32'(dif.remainder), 32'(e.r));
         chk("div_by_zero", 32'(dif.div_by_zero), 32'(e.dbz));
         if (!e.dbz) begin
            chk("invariant", 32'(dif.quotient) * 32'(e.b) + 32'(dif.remainder), 32'(e.a));
            chk("rem_lt_div", 32'(dif.remainder < e.b), 32'd1);
         end else begin
            dbz_seen++;
         end
         hold_q    = e.q;
         hold_r    = e.r;
         hold_dbz  = e.dbz;
         have_hold = 1'b1;
      end else if (chk_busy && have_hold && cyc >= free_cyc) begin
         chk("hold_quotient", 32'(dif.quotient), 32'(hold_q));
         chk("hold_remainder", 32'(dif.remainder), 32'(hold_r));
         chk("hold_dbz", 32'(dif.div_by_zero), 32'(hold_dbz));
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && cyc < free_cyc; i++) step();
   endtask

   task automatic op(input logic [7:0] a, input logic [3:0] b);
      wait_idle();
      dif.dividend = a;
      dif.divisor  = b;
      dif.start    = 1'b1;
      step();
      dif.start = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && sb.size() > 0; i++) step();
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, 32'(dif.busy), 32'd0);
      chk({tag, "_done"}, 32'(dif.done), 32'd0);
      chk({tag, "_quotient"}, 32'(dif.quotient), 32'd0);
      chk({tag, "_remainder"}, 32'(dif.remainder), 32'd0);
      chk({tag, "_dbz"}, 32'(dif.div_by_zero), 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      dif.start    = 1'b0;
      dif.dividend = 8'd0;
      dif.divisor  = 4'd0;

      // Reset state.
      step();
      step();
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      step();

      // Basic and edge operands.
      op(8'd200, 4'd7);
      drain("drain_basic");
      op(8'd255, 4'd1);
      op(8'd0, 4'd5);
      op(8'd14, 4'd15);
      op(8'd255, 4'd15);
      drain("drain_edges");

      // Divide by zero, then a normal op clears the flag.
      op(8'd37, 4'd0);
      op(8'd37, 4'd3);
      drain("drain_dbz");

      // Start pulse while busy is ignored; operands change mid-flight.
      op(8'd100, 4'd9);
      step();
      step();
      dif.dividend = 8'd50;
      dif.divisor  = 4'd2;
      dif.start    = 1'b1;
      step();
      dif.start = 1'b0;
      drain("drain_busy_start");

      // Start held high: second op accepted on the first IDLE edge.
      wait_idle();
      dif.dividend = 8'd20;
      dif.divisor  = 4'd3;
      dif.start    = 1'b1;
      step();
      dif.dividend = 8'd21;
      dif.divisor  = 4'd4;
      for (int i = 0; i < 12; i++) step();
      dif.start = 1'b0;
      drain("drain_held_start");

      // Asynchronous reset in the middle of an operation.
      wait_idle();
      dif.dividend = 8'd200;
      dif.divisor  = 4'd7;
      dif.start    = 1'b1;
      step();
      dif.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      chk_zero_outputs("midrst");
      sb.delete();
      acc_cyc   = cyc;
      free_cyc  = cyc;
      have_hold = 1'b0;
      step();
      step();
      chk_zero_outputs("midrst_hold");
      rst_n = 1'b1;
      op(8'd9, 4'd3);
      drain("drain_after_reset");

      // Exhaustive sweep of all operand pairs.
      chk_busy = 1'b0;
      dbz_seen = 0;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            op(8'(a), 4'(b));
         end
      end
      drain("drain_exhaustive");
      chk("dbz_count", 32'(dbz_seen), 32'd256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_restoring_divider
